mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit of the multicycle MIPS datapath, executing MULT, MULTU, DIV and DIVU. It holds the architectural Hi and Lo registers. Hi and Lo are direct data inputs of the 32-bit write-back selection mux that serves MFHI/MFLO. The control FSM starts it with a one-cycle pulse and stalls on `busy` until `done`.

## Interface
Parameters:
- None. The datapath is fixed at 32 bits and the iteration count at 32.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide.
- `is_signed`  in  1  1 = MULT/DIV (two's complement), 0 = MULTU/DIVU.
- `A`  in  32  multiplicand or dividend (rs).
- `B`  in  32  multiplier or divisor (rt).
- `Hi`  out  32  high product word or remainder.
- `Lo`  out  32  low product word or quotient.
- `busy`  out  1  high from acceptance until `done` asserts.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  high together with `done` when a divide had B = 0.

## Operation
- FSM states are IDLE, CALC, FIX and DONE.
- **IDLE, start = 1:**
  - Latch op and sign mode.
  - Latch |A| and |B| (magnitudes only when `is_signed`).
  - Latch sign flags for product/quotient (sign(A) XOR sign(B)) and for remainder (sign(A)).
  - Clear the iteration counter and go to CALC.
- **Divide with B = 0:** go to DONE instead of CALC, with `div_zero` = 1. Hi and Lo are left unchanged.
- **CALC, multiply:** unsigned shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring division on a 64-bit {remainder, quotient} register, one quotient bit per cycle.
- **CALC exit:** after 32 iterations (counter 0..31), go to FIX.
- **FIX:**
  - Apply sign correction: negate the 64-bit product if the product sign flag is set.
  - Negate the quotient if the quotient sign flag is set.
  - Negate the remainder if the dividend was negative.
  - Write Hi/Lo, then go to DONE.
- **Results:**
  - Multiply: Hi:Lo = full 64-bit product.
  - Divide: Lo = quotient, Hi = remainder.
  - All arithmetic is modulo 2^32 per word. Signed 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000 and Hi = 0, with no flag.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- `start` in CALC, FIX or DONE is ignored (no queueing).
- Hi and Lo hold their value between operations. They change only on a FIX write.
- **Reset values:** Hi = Lo = 0, `busy` = `done` = `div_zero` = 0, state IDLE, counter 0.

## Timing
- Accept `start` at edge N.
- `busy` = 1 after edge N.
- Iterations run on edges N+1..N+32.
- FIX performs the Hi/Lo write at edge N+33. At the same edge the state becomes DONE, `done` = 1 and `busy` = 0.
- Edge N+34 returns to IDLE with `done` = 0.
- Total latency is 33 cycles.
- Divide by zero: DONE is reached at edge N+1, with `done` = `div_zero` = 1 for one cycle.
- The earliest next accept is edge N+35 (N+3 after a divide by zero).
- Hi/Lo are stable and valid in the `done` cycle.
- `reset_n` low at any point, including mid-CALC, immediately returns all outputs to their reset values. The operation is lost.

## Structure
- Shared CPU package provides:
  - `md_state_t` enum {IDLE, CALC, FIX, DONE}.
  - `md_op_t` {MD_MUL, MD_DIV}.
  - Constant `MD_ITER` = 32.
- Single module with no sub-module. Datapath and FSM together come to roughly 200 lines.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. `done` is a single pulse at edge N+33 and `busy` is high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. Then DIVU 100 / 7 -> Lo = 0x0000000E, Hi = 0x00000002.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0, `div_zero` = 0.
- DIVU after a prior result Hi = 0x2, Lo = 0xE, with A = 5 and B = 0 -> `done` = `div_zero` = 1 at edge N+1, Hi/Lo unchanged.
- Start MULT and pulse `start` again at iteration 5 -> the second pulse is ignored. Assert `reset_n` low at iteration 10 -> Hi = Lo = 0, `busy` = `done` = 0 immediately, and no `done` follows.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_t;

    localparam int unsigned MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural Hi/Lo registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in FIX.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic        is_signed,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    md_state_t   r_state, w_state_nxt;
    md_op_t      r_op;
    logic        r_neg_q, r_neg_r, r_dz;
    logic [4:0]  r_cnt;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic [31:0] r_hi, r_lo;

    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_trial;
    logic        w_rem_ge;
    logic [31:0] w_rem_sub;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;
    logic [31:0] w_fix_hi, w_fix_lo;

    always_comb begin
        w_abs_a = (is_signed && A[31]) ? (32'd0 - A) : A;
        w_abs_b = (is_signed && B[31]) ? (32'd0 - B) : B;
    end

    // r_opnd is the multiplicand for MUL and the divisor for DIV
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
        w_rem_trial = r_acc[63:31];
        w_rem_ge    = (w_rem_trial >= {1'b0, r_opnd});
        w_rem_sub   = w_rem_trial[31:0] - r_opnd;
        w_acc_nxt   = '0;
        if (r_op == MD_MUL)
            w_acc_nxt = {w_mul_sum, r_acc[31:1]};
        else if (w_rem_ge)
            w_acc_nxt = {w_rem_sub, r_acc[30:0], 1'b1};
        else
            w_acc_nxt = {r_acc[62:0], 1'b0};
    end

    always_comb begin
        w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
        w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
        if (r_op == MD_MUL) begin
            w_fix_hi = w_prod[63:32];
            w_fix_lo = w_prod[31:0];
        end else begin
            w_fix_hi = w_rem;
            w_fix_lo = w_quo;
        end
    end

    // A divide by zero still spends one cycle in CALC so DONE lands at N+1
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = CALC;
            CALC: begin
                if (r_dz)
                    w_state_nxt = DONE;
                else if (r_cnt == 5'(MD_ITER - 1))
                    w_state_nxt = FIX;
            end
            FIX:  w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= MD_MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_op    <= md_op_t'(op);
                    r_cnt   <= '0;
                    r_neg_q <= is_signed & (A[31] ^ B[31]);
                    r_neg_r <= is_signed & A[31];
                    r_dz    <= op & (B == 32'd0);
                    r_opnd  <= op ? w_abs_b : w_abs_a;
                    r_acc   <= {32'd0, (op ? w_abs_a : w_abs_b)};
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign Hi       = r_hi;
    assign Lo       = r_lo;
    assign busy     = (r_state == CALC) || (r_state == FIX);
    assign done     = (r_state == DONE);
    assign div_zero = (r_state == DONE) && r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op;
    logic        is_signed;
    logic [31:0] A, B;
    logic [31:0] Hi, Lo;
    logic        busy, done, div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .is_signed(is_signed),
        .A        (A),
        .B        (B),
        .Hi       (Hi),
        .Lo       (Lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // MIPS semantics from plain 64-bit arithmetic; divide by zero keeps Hi/Lo
    task automatic ref_model(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        logic [63:0]     v;
        rdz = 1'b0;
        rh  = exp_hi;
        rl  = exp_lo;
        sa  = $signed(a);
        sb  = $signed(b);
        if (!o) begin
            if (s) begin
                sp = sa * sb;
                v  = sp;
            end else begin
                up = {32'd0, a} * {32'd0, b};
                v  = up;
            end
            rh = v[63:32];
            rl = v[31:0];
        end else if (b == 32'd0) begin
            rdz = 1'b1;
        end else if (s) begin
            sq = sa / sb;
            sr = sa % sb;
            v  = sq;
            rl = v[31:0];
            v  = sr;
            rh = v[31:0];
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endtask

    task automatic run_op(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, input string tag);
        logic [31:0] eh, el;
        logic        edz;
        int          k, nb, lat;
        ref_model(o, s, a, b, eh, el, edz);
        lat = edz ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; is_signed = s; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
        k = 0; nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            if (k == pulse_at) begin
                @(negedge clk);
                start = 1'b1; op = ~o; A = 32'd9; B = 32'd9;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_busycyc"}, 64'(nb), 64'(lat));
        check({tag, "_hi"}, 64'(Hi), 64'(eh));
        check({tag, "_lo"}, 64'(Lo), 64'(el));
        check({tag, "_dz"}, 64'(div_zero), 64'(edz));
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, "_done_low"}, 64'(done), 64'd0);
        exp_hi = eh;
        exp_lo = el;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone;
        reset_n = 1'b0; start = 1'b0; op = 1'b0; is_signed = 1'b0; A = '0; B = '0;
        #12;
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, -1, "mult_neg");
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        run_op(1'b1, 1'b0, 32'd100, 32'd7, -1, "divu");
        run_op(1'b1, 1'b0, 32'd5, 32'd0, -1, "divu_zero");
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        run_op(1'b0, 1'b1, 32'd3, 32'd5, 5, "mult_ignore");

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick_val(), pick_val(), -1, "rnd");

        // Reset in the middle of CALC loses the operation
        @(negedge clk);
        start = 1'b1; op = 1'b0; is_signed = 1'b0; A = 32'd1234; B = 32'd5678;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_hi", 64'(Hi), 64'd0);
        check("midrst_lo", 64'(Lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, -1, "post_rst_div");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
